// File: rtl/seq_cmp_timer_if.sv
// Bundle of control, operand and status signals for seq_cmp_timer.
// The master drives the request/operands; the slave (the timer) drives status.
interface seq_cmp_timer_if #(
   parameter int unsigned W     = 8,
   parameter int unsigned CW    = 10,
   parameter int unsigned DEPTH = 3
);
   logic                 start;
   logic                 abort;
   logic                 mode;
   logic [W-1:0]         a;
   logic [W-1:0]         b;
   logic [2:0]           state;
   logic [3*DEPTH-1:0]   hist;
   logic [CW-1:0]        cnt;
   logic [W-1:0]         a_q;
   logic                 match;
   logic                 done;
   logic                 busy;

   modport master (
      output start, abort, mode, a, b,
      input  state, hist, cnt, a_q, match, done, busy
   );

   modport slave (
      input  start, abort, mode, a, b,
      output state, hist, cnt, a_q, match, done, busy
   );
endinterface

// File: rtl/seq_cmp_timer.sv
// Sequenced compare-then-wait timer: captures operands, registers a compare
// result, dwells TERM cycles in WAIT and pulses done, with abort and state history.
module seq_cmp_timer #(
   parameter int unsigned W     = 8,
   parameter int unsigned CW    = 10,
   parameter int unsigned TERM  = 1000,
   parameter int unsigned DEPTH = 3
) (
   input logic            i_n0,
   input logic            i_n1,
   seq_cmp_timer_if.slave s_if
);
   localparam int unsigned HW      = 3 * DEPTH;
   localparam logic [CW-1:0] TERM_M1 = CW'(TERM - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_CMP  = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [HW-1:0]   r_hist;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_a_q;
   logic [W-1:0]    r_b_q;
   logic            r_mode_q;
   logic            r_match;
   logic            r_done;
   logic            r_busy;

   // State register
   always_ff @(posedge i_n0) begin
      if (i_n1) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic; abort outranks the terminal count, illegal codes recover to IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (s_if.start) w_state_nxt = S_LOAD;
         S_LOAD: w_state_nxt = S_CMP;
         S_CMP:  w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (s_if.abort)            w_state_nxt = S_IDLE;
            else if (r_cnt == TERM_M1) w_state_nxt = S_DONE;
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath, history and registered status flags
   always_ff @(posedge i_n0) begin
      if (i_n1) begin
         r_hist   <= '0;
         r_cnt    <= '0;
         r_a_q    <= '0;
         r_b_q    <= '0;
         r_mode_q <= 1'b0;
         r_match  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         r_hist[2:0] <= r_state;
         for (int k = 1; k < int'(DEPTH); k++) begin
            r_hist[3*k +: 3] <= r_hist[3*(k-1) +: 3];
         end
         case (r_state)
            S_LOAD: begin
               r_a_q    <= s_if.a;
               r_b_q    <= s_if.b;
               r_mode_q <= s_if.mode;
            end
            S_CMP: begin
               r_match <= r_mode_q ? (r_a_q >= r_b_q) : (r_a_q == r_b_q);
               r_cnt   <= '0;
            end
            S_WAIT: begin
               if (s_if.abort)            r_cnt <= '0;
               else if (r_cnt != TERM_M1) r_cnt <= r_cnt + CW'(1);
            end
            // Count is held through DONE and cleared on the way back to IDLE
            S_DONE: r_cnt <= '0;
            default: ;
         endcase
      end
   end

   assign s_if.state = r_state;
   assign s_if.hist  = r_hist;
   assign s_if.cnt   = r_cnt;
   assign s_if.a_q   = r_a_q;
   assign s_if.match = r_match;
   assign s_if.done  = r_done;
   assign s_if.busy  = r_busy;
endmodule
